// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encodings and
// the per-stage enable/flush control bundle.
package pipe_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_EX_WAIT  = 2'd1;
  localparam state_t ST_MEM_WAIT = 2'd2;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  typedef struct packed {
    logic        pc_en;
    logic        pc_redirect;
    stage_ctrl_t if_id;
    stage_ctrl_t id_ex;
    stage_ctrl_t ex_mem;
    stage_ctrl_t mem_wb;
  } ctrl_t;

  // Free-running pipeline: everything advances, nothing is squashed.
  function automatic ctrl_t ctrl_run();
    ctrl_t c;
    c.pc_en       = 1'b1;
    c.pc_redirect = 1'b0;
    c.if_id       = '{en: 1'b1, flush: 1'b0};
    c.id_ex       = '{en: 1'b1, flush: 1'b0};
    c.ex_mem      = '{en: 1'b1, flush: 1'b0};
    c.mem_wb      = '{en: 1'b1, flush: 1'b0};
    return c;
  endfunction

  // Controls presented while the core is held in reset.
  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c.pc_en       = 1'b0;
    c.pc_redirect = 1'b0;
    c.if_id       = '{en: 1'b0, flush: 1'b1};
    c.id_ex       = '{en: 1'b0, flush: 1'b1};
    c.ex_mem      = '{en: 1'b0, flush: 1'b1};
    c.mem_wb      = '{en: 1'b0, flush: 1'b1};
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_timer.sv
// Loadable saturating up/down counter; times both MDU occupancy and MEM waits.
// Priority: clr > load > inc (stops at MAX) > dec (stops at 0).
module pipe_ctrl_timer #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (inc) begin
      if (count_q != MAX_V) count_d = count_q + WIDTH'(1);
    end else if (dec) begin
      if (count_q != '0) count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: merges MEM waits, multi-cycle
// EX ops, mispredicts and load-use into PC/pipeline-register controls.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT     = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load_use,
  input  logic        i_br_mispredict,
  input  logic        i_ex_multicycle,
  input  logic        i_dmem_req,
  input  logic        i_dmem_ack,
  output logic        o_pc_en,
  output logic        o_pc_redirect,
  output logic        o_if_id_en,
  output logic        o_id_ex_en,
  output logic        o_ex_mem_en,
  output logic        o_mem_wb_en,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic        o_ex_mem_flush,
  output logic        o_mem_wb_flush,
  output logic        o_mdu_start,
  output logic        o_timeout_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_events
`endif
);

  localparam int MDU_W = $clog2(MDU_LAT + 1);
  localparam int MEM_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [MDU_W-1:0] MDU_RELOAD = MDU_W'(MDU_LAT - 2);
  localparam logic [MEM_W-1:0] MEM_LAST   = MEM_W'(MEM_TIMEOUT - 1);

  state_t state_q, state_d;
  state_t ret_q, ret_d;
  logic   timeout_err_q, timeout_err_d;

  logic [MDU_W-1:0] mdu_cnt;
  logic [MEM_W-1:0] wait_cnt;

  logic   mem_stall;
  state_t eff_state;
  logic   ex_launch;
  logic   ex_busy;
  logic   mdu_load;
  logic   mdu_dec;
  logic   mdu_start;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;

  assign mem_stall = i_dmem_req & ~i_dmem_ack;

  // When a MEM wait releases, the cycle is evaluated as if already back in the
  // state that was interrupted, so a deferred launch/advance happens right away.
  assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
  assign ex_launch = (eff_state == ST_RUN) & i_ex_multicycle;
  assign ex_busy   = ex_launch | ((eff_state == ST_EX_WAIT) & (mdu_cnt != '0));

  // NOTE: every signal driven here gets a default first, so no path through
  // the if/else tree leaves it unassigned and no latch is inferred.
  always_comb begin
    ctrl      = ctrl_run();
    state_d   = state_q;
    ret_d     = ret_q;
    mdu_load  = 1'b0;
    mdu_dec   = 1'b0;
    mdu_start = 1'b0;

    if (mem_stall) begin
      ctrl.pc_en        = 1'b0;
      ctrl.if_id.en     = 1'b0;
      ctrl.id_ex.en     = 1'b0;
      ctrl.ex_mem.en    = 1'b0;
      ctrl.mem_wb.flush = 1'b1;
      if (state_q != ST_MEM_WAIT) begin
        ret_d   = state_q;
        state_d = ST_MEM_WAIT;
      end
    end else begin
      state_d = eff_state;
      if (ex_busy) begin
        ctrl.pc_en        = 1'b0;
        ctrl.if_id.en     = 1'b0;
        ctrl.id_ex.en     = 1'b0;
        ctrl.ex_mem.flush = 1'b1;
        if (eff_state == ST_RUN) begin
          mdu_load  = 1'b1;
          mdu_start = 1'b1;
          state_d   = ST_EX_WAIT;
        end else begin
          mdu_dec = 1'b1;
        end
      end else begin
        // EX advances this cycle; the finishing MDU op must not relaunch.
        if (eff_state == ST_EX_WAIT) state_d = ST_RUN;
        if (i_br_mispredict) begin
          ctrl.pc_redirect = 1'b1;
          ctrl.if_id.flush = 1'b1;
          ctrl.id_ex.flush = 1'b1;
        end else if (i_load_use) begin
          ctrl.pc_en       = 1'b0;
          ctrl.if_id.en    = 1'b0;
          ctrl.id_ex.flush = 1'b1;
        end
      end
    end
  end

  assign timeout_err_d = timeout_err_q | (mem_stall & (wait_cnt >= MEM_LAST));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= ST_RUN;
      ret_q         <= ST_RUN;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  pipe_ctrl_timer #(
    .WIDTH (MDU_W),
    .MAX   (MDU_LAT)
  ) u_mdu_timer (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .clr      (1'b0),
    .load     (mdu_load),
    .load_val (MDU_RELOAD),
    .inc      (1'b0),
    .dec      (mdu_dec),
    .count    (mdu_cnt)
  );

  // Counts consecutive stalled MEM cycles; cleared as soon as the stall ends.
  pipe_ctrl_timer #(
    .WIDTH (MEM_W),
    .MAX   (MEM_TIMEOUT)
  ) u_mem_timer (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .clr      (~mem_stall),
    .load     (1'b0),
    .load_val ('0),
    .inc      (mem_stall),
    .dec      (1'b0),
    .count    (wait_cnt)
  );

  assign ctrl_out = i_reset ? ctrl : ctrl_reset();

  assign o_pc_en        = ctrl_out.pc_en;
  assign o_pc_redirect  = ctrl_out.pc_redirect;
  assign o_if_id_en     = ctrl_out.if_id.en;
  assign o_id_ex_en     = ctrl_out.id_ex.en;
  assign o_ex_mem_en    = ctrl_out.ex_mem.en;
  assign o_mem_wb_en    = ctrl_out.mem_wb.en;
  assign o_if_id_flush  = ctrl_out.if_id.flush;
  assign o_id_ex_flush  = ctrl_out.id_ex.flush;
  assign o_ex_mem_flush = ctrl_out.ex_mem.flush;
  assign o_mem_wb_flush = ctrl_out.mem_wb.flush;
  assign o_mdu_start    = mdu_start & i_reset;
  assign o_timeout_err  = timeout_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + (o_pc_en ? 32'd0 : 32'd1);
    flush_events_d = flush_events_q + (o_pc_redirect ? 32'd1 : 32'd0);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed testbench for pipe_ctrl_unit (MDU_LAT=4, MEM_TIMEOUT=64).
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_pipe_ctrl_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic load_use, br, mc, req, ack;

  logic pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, mdu_start, timeout_err;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(
    .MDU_LAT     (4),
    .MEM_TIMEOUT (64)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_load_use      (load_use),
    .i_br_mispredict (br),
    .i_ex_multicycle (mc),
    .i_dmem_req      (req),
    .i_dmem_ack      (ack),
    .o_pc_en         (pc_en),
    .o_pc_redirect   (pc_redirect),
    .o_if_id_en      (if_id_en),
    .o_id_ex_en      (id_ex_en),
    .o_ex_mem_en     (ex_mem_en),
    .o_mem_wb_en     (mem_wb_en),
    .o_if_id_flush   (if_id_fl),
    .o_id_ex_flush   (id_ex_fl),
    .o_ex_mem_flush  (ex_mem_fl),
    .o_mem_wb_flush  (mem_wb_fl),
    .o_mdu_start     (mdu_start),
    .o_timeout_err   (timeout_err)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .o_stall_cycles  (stall_cycles),
    .o_flush_events  (flush_events)
`endif
  );

  // {pc_en, redirect, en[if_id,id_ex,ex_mem,mem_wb], flush[same], mdu_start, timeout}
  logic [11:0] obs;
  assign obs = {pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, mdu_start, timeout_err};

  localparam logic [11:0] V_RUN    = 12'b1_0_1111_0000_0_0;
  localparam logic [11:0] V_RST    = 12'b0_0_0000_1111_0_0;
  localparam logic [11:0] V_LU     = 12'b0_0_0111_0100_0_0;
  localparam logic [11:0] V_EXB    = 12'b0_0_0011_0010_0_0;
  localparam logic [11:0] V_LAUNCH = 12'b0_0_0011_0010_1_0;
  localparam logic [11:0] V_MEM    = 12'b0_0_0001_0001_0_0;
  localparam logic [11:0] V_BR     = 12'b1_1_1111_1100_0_0;

  task automatic idle_inputs();
    load_use = 1'b0; br = 1'b0; mc = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    tests++;
    if (obs !== V_RST) begin
      failed++;
      $display("FAIL reset_outputs got %b want %b", obs, V_RST);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (obs !== V_RUN) begin
      failed++;
      $display("FAIL post_reset_run got %b want %b", obs, V_RUN);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk); load_use = 1'b1; #1;
    tests++;
    if (obs !== V_LU) begin
      failed++;
      $display("FAIL load_use_hold got %b want %b", obs, V_LU);
    end
    @(negedge clk); load_use = 1'b0; #1;
    tests++;
    if (obs !== V_RUN) begin
      failed++;
      $display("FAIL load_use_release got %b want %b", obs, V_RUN);
    end
  endtask

  task automatic test_mdu();
    logic [11:0] exp_seq [5];
    exp_seq = '{V_LAUNCH, V_EXB, V_EXB, V_RUN, V_RUN};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mc = (i < 4);
      #1;
      tests++;
      if (obs !== exp_seq[i]) begin
        failed++;
        $display("FAIL mdu_cycle%0d got %b want %b", i, obs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Two MDU ops in a row: the advancing cycle must not relaunch, the next must.
    logic [11:0] exp_seq [8];
    exp_seq = '{V_LAUNCH, V_EXB, V_EXB, V_RUN, V_LAUNCH, V_EXB, V_EXB, V_RUN};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); mc = 1'b1; #1;
      tests++;
      if (obs !== exp_seq[i]) begin
        failed++;
        $display("FAIL b2b_mdu_cycle%0d got %b want %b", i, obs, exp_seq[i]);
      end
    end
    @(negedge clk); mc = 1'b0;
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); req = 1'b1; ack = 1'b0; #1;
      tests++;
      if (obs !== V_MEM) begin
        failed++;
        $display("FAIL mem_wait_cycle%0d got %b want %b", i, obs, V_MEM);
      end
    end
    @(negedge clk); ack = 1'b1; #1;
    tests++;
    if (obs !== V_RUN) begin
      failed++;
      $display("FAIL mem_ack got %b want %b", obs, V_RUN);
    end
    @(negedge clk); req = 1'b0; ack = 1'b0; #1;
    tests++;
    if (obs !== V_RUN) begin
      failed++;
      $display("FAIL mem_after_ack got %b want %b", obs, V_RUN);
    end
  endtask

  task automatic test_mispredict_mem();
    int redirects = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req = 1'b1; ack = 1'b0; br = 1'b1; #1;
      redirects += int'(pc_redirect);
      tests++;
      if (obs !== V_MEM) begin
        failed++;
        $display("FAIL br_mem_stall%0d got %b want %b", i, obs, V_MEM);
      end
    end
    @(negedge clk); ack = 1'b1; #1;
    redirects += int'(pc_redirect);
    tests++;
    if (obs !== V_BR) begin
      failed++;
      $display("FAIL br_on_ack got %b want %b", obs, V_BR);
    end
    @(negedge clk); idle_inputs(); #1;
    redirects += int'(pc_redirect);
    tests++;
    if (obs !== V_RUN) begin
      failed++;
      $display("FAIL br_after got %b want %b", obs, V_RUN);
    end
    tests++;
    if (redirects !== 1) begin
      failed++;
      $display("FAIL br_redirect_count got %0d want 1", redirects);
    end
  endtask

  task automatic test_mdu_mem_br();
    // Launch, one busy cycle, two MEM stalls (count frozen), then resume with
    // one busy cycle and advance; mispredict is held throughout.
    logic [11:0] exp_seq [7];
    logic        rq [7];
    logic        ak [7];
    exp_seq = '{V_LAUNCH, V_EXB, V_MEM, V_MEM, V_EXB, V_BR, V_RUN};
    rq      = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ak      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      mc = (i < 6); br = (i < 6); req = rq[i]; ack = ak[i];
      #1;
      tests++;
      if (obs !== exp_seq[i]) begin
        failed++;
        $display("FAIL mdu_mem_br_cycle%0d got %b want %b", i, obs, exp_seq[i]);
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_timeout();
    logic [11:0] exp_v;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk); req = 1'b1; ack = 1'b0; #1;
      exp_v = V_MEM | ((i >= 64) ? 12'd1 : 12'd0);
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL timeout_cycle%0d got %b want %b", i, obs, exp_v);
      end
    end
    @(negedge clk); ack = 1'b1; #1;
    tests++;
    if (obs !== (V_RUN | 12'd1)) begin
      failed++;
      $display("FAIL timeout_ack got %b want %b", obs, V_RUN | 12'd1);
    end
    @(negedge clk); idle_inputs(); #1;
    tests++;
    if (obs !== (V_RUN | 12'd1)) begin
      failed++;
      $display("FAIL timeout_sticky got %b want %b", obs, V_RUN | 12'd1);
    end
  endtask

  task automatic test_reset_mid_ex();
    @(negedge clk); mc = 1'b1; #1;
    tests++;
    if (obs !== (V_LAUNCH | 12'd1)) begin
      failed++;
      $display("FAIL rst_mid_launch got %b want %b", obs, V_LAUNCH | 12'd1);
    end
    @(negedge clk); rst_n = 1'b0; #1;
    tests++;
    if (obs !== V_RST) begin
      failed++;
      $display("FAIL rst_mid_ex_outputs got %b want %b", obs, V_RST);
    end
    @(negedge clk); mc = 1'b0; #1;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (obs !== V_RUN) begin
        failed++;
        $display("FAIL rst_release_cycle%0d got %b want %b", i, obs, V_RUN);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_mdu();
    test_back_to_back();
    test_mem_wait();
    test_mispredict_mem();
    test_mdu_mem_br();
    test_timeout();
    test_reset_mid_ex();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
